// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port SRAM (combinational read, posedge write) between
// NUM_REQ requesters. Arbitration is round-robin. A burst (req_last=0 beats)
// locks the port to its owner until the owner's last beat is accepted. Every
// SRAM-side signal comes from a register, so the SRAM gets a full cycle to
// settle its read data. Read data returns one cycle later with a one-hot tag
// that names the requester that issued the read.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8; 1 also works)
//   ADDR_WIDTH  SRAM address width
//   DATA_WIDTH  SRAM data width
//
// Ports:
//   clock            single clock, all state changes on posedge
//   reset_b          asynchronous active-low reset
//   req_valid        per-requester request valid
//   req_ready        per-requester grant (combinational, at most one-hot)
//   req_write        per-requester 1 = write beat, 0 = read beat
//   req_last         per-requester final beat of a burst
//   req_addr         packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata        packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid        one-hot read-response strobe
//   rsp_data         read data; holds its value while rsp_valid is 0
//   sram_address     registered SRAM address
//   sram_write_data  registered SRAM write data
//   sram_enable      registered SRAM enable
//   sram_write       registered SRAM write strobe
//   sram_read_data   SRAM read data (combinational from sram_address)
//
// Optional build macro SRAM_PORT_ARBITER_STATS_EN adds:
//   stat_grants      NUM_REQ saturating 16-bit counts of accepted beats
//   stat_conflicts   saturating 16-bit count of contended cycles
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset_b,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          sram_address,
    output logic [DATA_WIDTH-1:0]          sram_write_data,
    output logic                           sram_enable,
    output logic                           sram_write,
    input  logic [DATA_WIDTH-1:0]          sram_read_data
`ifdef SRAM_PORT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          stat_grants,
    output logic [15:0]                    stat_conflicts
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        owner_q;
    logic [IDX_W-1:0]        ptr_q;

    logic [NUM_REQ-1:0]      grantVec;
    logic [NUM_REQ-1:0]      upperValid;
    logic [NUM_REQ-1:0]      candVec;
    logic [IDX_W-1:0]        grantIdx;
    logic [IDX_W-1:0]        nextPtr;
    logic                    acceptBeat;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selWdata;
    logic                    selWrite;
    logic                    selLast;

    logic [ADDR_WIDTH-1:0]   sramAddress_q;
    logic [DATA_WIDTH-1:0]   sramWdata_q;
    logic                    sramEnable_q;
    logic                    sramWrite_q;
    logic [NUM_REQ-1:0]      portOwner_q;
    logic [NUM_REQ-1:0]      rspValid_q;
    logic [DATA_WIDTH-1:0]   rspData_q;

    // Grant selection. While locked only the owner may be granted. While idle
    // the search starts at ptr_q: requesters at or above the pointer are tried
    // first (lowest index wins), and only if none of them is valid does the
    // search wrap around to the lowest valid index overall.
    always_comb begin
        grantVec   = '0;
        upperValid = '0;
        candVec    = '0;
        if (state_q == LOCKED) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDX_W'(i) == owner_q) begin
                    grantVec[i] = req_valid[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                upperValid[i] = req_valid[i] && (IDX_W'(i) >= ptr_q);
            end
            candVec = (|upperValid) ? upperValid : req_valid;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (candVec[i]) begin
                    grantVec = NUM_REQ'(1) << i;
                end
            end
        end
    end

    // Encode the granted requester and mux its beat onto the shared port.
    always_comb begin
        grantIdx = '0;
        selAddr  = '0;
        selWdata = '0;
        selWrite = 1'b0;
        selLast  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                grantIdx = IDX_W'(i);
                selAddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                selWdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                selWrite = req_write[i];
                selLast  = req_last[i];
            end
        end
    end

    assign acceptBeat = |grantVec;
    assign nextPtr    = (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);

    // The grant is combinational, so it is masked while reset is held to keep
    // every output at zero during reset.
    assign req_ready = grantVec & {NUM_REQ{reset_b}};

    // Arbitration FSM: a non-last beat locks the port to its requester; a last
    // beat releases it and moves the round-robin pointer past the winner.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (acceptBeat) begin
            if (selLast) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= nextPtr;
            end else begin
                state_q <= LOCKED;
                owner_q <= grantIdx;
            end
        end
    end

    // Port stage: registers the accepted beat towards the SRAM. Address and
    // data hold on idle cycles; only enable and write drop back to zero.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            sramAddress_q <= '0;
            sramWdata_q   <= '0;
            sramEnable_q  <= 1'b0;
            sramWrite_q   <= 1'b0;
            portOwner_q   <= '0;
        end else begin
            sramEnable_q <= acceptBeat;
            sramWrite_q  <= acceptBeat & selWrite;
            if (acceptBeat) begin
                sramAddress_q <= selAddr;
                sramWdata_q   <= selWdata;
                portOwner_q   <= grantVec;
            end
        end
    end

    // Response stage: a read port cycle ends by capturing the settled SRAM
    // data and tagging it with the requester that owned that port cycle.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            rspValid_q <= '0;
            rspData_q  <= '0;
        end else if (sramEnable_q && !sramWrite_q) begin
            rspValid_q <= portOwner_q;
            rspData_q  <= sram_read_data;
        end else begin
            rspValid_q <= '0;
        end
    end

    assign sram_address    = sramAddress_q;
    assign sram_write_data = sramWdata_q;
    assign sram_enable     = sramEnable_q;
    assign sram_write      = sramWrite_q;
    assign rsp_valid       = rspValid_q;
    assign rsp_data        = rspData_q;

`ifdef SRAM_PORT_ARBITER_STATS_EN
    logic [15:0]         grantCount_q [NUM_REQ];
    logic [15:0]         conflictCount_q;
    logic [NUM_REQ-1:0]  ownerMask;
    logic                conflictCycle;

    // A cycle is contended when two or more requesters are valid, or when a
    // requester other than the lock owner is left waiting on a locked port.
    always_comb begin
        ownerMask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == owner_q) begin
                ownerMask[i] = 1'b1;
            end
        end
        conflictCycle = ($countones(req_valid) >= 2) ||
                        ((state_q == LOCKED) && (|(req_valid & ~ownerMask)));
    end

    // Saturating counters: they stop at 16'hFFFF instead of wrapping.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grantCount_q[i] <= '0;
            end
            conflictCount_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantVec[i] && (grantCount_q[i] != 16'hFFFF)) begin
                    grantCount_q[i] <= grantCount_q[i] + 16'd1;
                end
            end
            if (conflictCycle && (conflictCount_q != 16'hFFFF)) begin
                conflictCount_q <= conflictCount_q + 16'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grantCount_q[i];
        end
    end

    assign stat_conflicts = conflictCount_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter with NUM_REQ=3, 8-bit address,
// 16-bit data. A behavioural SRAM (combinational read, posedge write) is
// attached to the port. Expected read responses are queued when a read is
// issued and a negedge monitor pops them as the DUT presents rsp_valid.
// Every memory word starts out as 16'hA000 | address, except 0x10 = 16'hBEEF.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 16;

    logic              clock = 1'b0;
    logic              reset_b = 1'b1;
    logic [NR-1:0]     reqValid = '0;
    logic [NR-1:0]     reqReady;
    logic [NR-1:0]     reqWrite = '0;
    logic [NR-1:0]     reqLast = '0;
    logic [NR*AW-1:0]  reqAddr = '0;
    logic [NR*DW-1:0]  reqWdata = '0;
    logic [NR-1:0]     rspValid;
    logic [DW-1:0]     rspData;
    logic [AW-1:0]     sramAddress;
    logic [DW-1:0]     sramWriteData;
    logic              sramEnable;
    logic              sramWrite;
    logic [DW-1:0]     sramReadData;
`ifdef SRAM_PORT_ARBITER_STATS_EN
    logic [NR*16-1:0]  statGrants;
    logic [15:0]       statConflicts;
`endif

    sram_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock           (clock),
        .reset_b         (reset_b),
        .req_valid       (reqValid),
        .req_ready       (reqReady),
        .req_write       (reqWrite),
        .req_last        (reqLast),
        .req_addr        (reqAddr),
        .req_wdata       (reqWdata),
        .rsp_valid       (rspValid),
        .rsp_data        (rspData),
        .sram_address    (sramAddress),
        .sram_write_data (sramWriteData),
        .sram_enable     (sramEnable),
        .sram_write      (sramWrite),
        .sram_read_data  (sramReadData)
`ifdef SRAM_PORT_ARBITER_STATS_EN
        ,
        .stat_grants     (statGrants),
        .stat_conflicts  (statConflicts)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural SRAM attached to the arbiter's port.
    logic [DW-1:0] mem [256];
    assign sramReadData = mem[sramAddress];

    always @(posedge clock) begin
        if (sramEnable && sramWrite) begin
            mem[sramAddress] = sramWriteData;
        end
    end

    typedef struct {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t expQ [$];
    exp_t popped;
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;

    always @(posedge clock) cycleCount++;

    // Response monitor: every rsp_valid must match the oldest queued read,
    // in order and in the expected cycle; an overdue read is a failure.
    always @(negedge clock) begin
        if (expQ.size() > 0 && expQ[0].cyc < cycleCount) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_missing actual=none required=%b/%h at cycle %0d",
                     expQ[0].v, expQ[0].d, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (rspValid != '0) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL rsp_unexpected actual=%b/%h required=none cycle=%0d",
                         rspValid, rspData, cycleCount);
            end else begin
                popped = expQ.pop_front();
                if (rspValid !== popped.v || rspData !== popped.d || cycleCount != popped.cyc) begin
                    failures++;
                    $display("[TB] FAIL rsp_compare actual=%b/%h@%0d required=%b/%h@%0d",
                             rspValid, rspData, cycleCount, popped.v, popped.d, popped.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drives one requester's lane; the other lanes are left untouched.
    task automatic applyStimulus(input int idx, input logic valid, input logic write,
                                 input logic last, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        reqValid[idx]             = valid;
        reqWrite[idx]             = write;
        reqLast[idx]              = last;
        reqAddr[idx*AW +: AW]     = addr;
        reqWdata[idx*DW +: DW]    = wdata;
    endtask

    task automatic clearAll();
        reqValid = '0;
        reqWrite = '0;
        reqLast  = '0;
        reqAddr  = '0;
        reqWdata = '0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // The read accepted in the current cycle returns two edges later.
    task automatic expectRead(input logic [NR-1:0] v, input logic [DW-1:0] d);
        exp_t e;
        e.v   = v;
        e.d   = d;
        e.cyc = cycleCount + 2;
        expQ.push_back(e);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (expQ.size() > 0 && waited < 20) begin
            @(posedge clock);
            waited++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        drain();
        reset_b = 1'b0;
        clearAll();
        repeat (2) @(posedge clock);
        #1;
        reset_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'hA000 | 16'(i);
        end
        mem[8'h10] = 16'hBEEF;

        // Reset state, with a request pending to show the grant is masked.
        #1;
        reset_b = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_ready",   32'(reqReady),    32'h0);
        checkOutput("reset_rsp_v",   32'(rspValid),    32'h0);
        checkOutput("reset_rsp_d",   32'(rspData),     32'h0);
        checkOutput("reset_enable",  32'(sramEnable),  32'h0);
        checkOutput("reset_write",   32'(sramWrite),   32'h0);
        checkOutput("reset_address", 32'(sramAddress), 32'h0);
        clearAll();
        reset_b = 1'b1;

        // Single read of 0x10 by requester 0.
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0);
        #1;
        checkOutput("single_ready", 32'(reqReady), 32'h1);
        expectRead(3'b001, 16'hBEEF);
        nextCycle();
        clearAll();
        checkOutput("single_enable",  32'(sramEnable),  32'h1);
        checkOutput("single_address", 32'(sramAddress), 32'h10);
        checkOutput("single_write",   32'(sramWrite),   32'h0);
        nextCycle();
        checkOutput("idle_enable", 32'(sramEnable), 32'h0);
        drain();
        checkOutput("hold_rsp_v", 32'(rspValid), 32'h0);
        checkOutput("hold_rsp_d", 32'(rspData),  32'hBEEF);

        // Round robin: three continuous single-beat readers from reset.
        doReset();
        for (int i = 0; i < NR; i++) begin
            applyStimulus(i, 1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 16'h0);
        end
        for (int j = 0; j < 6; j++) begin
            #1;
            checkOutput("rr_ready", 32'(reqReady), 32'(1 << (j % 3)));
            expectRead(3'(1 << (j % 3)), 16'(16'hA020 + (j % 3)));
            nextCycle();
        end
        clearAll();
        drain();
`ifdef SRAM_PORT_ARBITER_STATS_EN
        checkOutput("stat_grants0",   32'(statGrants[15:0]),  32'd2);
        checkOutput("stat_grants1",   32'(statGrants[31:16]), 32'd2);
        checkOutput("stat_grants2",   32'(statGrants[47:32]), 32'd2);
        checkOutput("stat_conflicts", 32'(statConflicts),     32'd6);
`endif

        // Burst lock: move ptr to 1, then req1 bursts 4 reads against req0/req2.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h01, 16'h0);
        #1;
        checkOutput("prime_ready", 32'(reqReady), 32'h1);
        expectRead(3'b001, 16'hA001);
        nextCycle();
        clearAll();
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1, (j < 4), 1'b0, (j == 3), 8'(8'h30 + j), 16'h0);
            applyStimulus(0, (j < 6), 1'b0, 1'b1, 8'h40, 16'h0);
            applyStimulus(2, (j < 5), 1'b0, 1'b1, 8'h42, 16'h0);
            #1;
            if (j < 4) begin
                checkOutput("burst_ready", 32'(reqReady), 32'h2);
                expectRead(3'b010, 16'(16'hA030 + j));
            end else if (j == 4) begin
                checkOutput("burst_next_ready", 32'(reqReady), 32'h4);
                expectRead(3'b100, 16'hA042);
            end else begin
                checkOutput("burst_wrap_ready", 32'(reqReady), 32'h1);
                expectRead(3'b001, 16'hA040);
            end
            nextCycle();
        end
        clearAll();

        // Lock holds while the owner drops valid; ptr is 1 here.
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h60, 16'h0);
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 8'h62, 16'h0);
        #1;
        checkOutput("lock_first_ready", 32'(reqReady), 32'h2);
        expectRead(3'b010, 16'hA060);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        checkOutput("lock_hold_ready", 32'(reqReady), 32'h0);
        nextCycle();
        checkOutput("lock_idle_enable", 32'(sramEnable), 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'h61, 16'h0);
        #1;
        checkOutput("lock_resume_ready", 32'(reqReady), 32'h2);
        expectRead(3'b010, 16'hA061);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        checkOutput("lock_release_ready", 32'(reqReady), 32'h4);
        expectRead(3'b100, 16'hA062);
        nextCycle();
        clearAll();
        drain();

        // Write then read back the same address from requester 2.
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 8'h05, 16'h1234);
        #1;
        checkOutput("wr_ready", 32'(reqReady), 32'h4);
        nextCycle();
        checkOutput("wr_sram_write",   32'(sramWrite),     32'h1);
        checkOutput("wr_sram_enable",  32'(sramEnable),    32'h1);
        checkOutput("wr_sram_address", 32'(sramAddress),   32'h05);
        checkOutput("wr_sram_wdata",   32'(sramWriteData), 32'h1234);
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 8'h05, 16'h0);
        #1;
        checkOutput("rd_ready", 32'(reqReady), 32'h4);
        expectRead(3'b100, 16'h1234);
        nextCycle();
        clearAll();
        checkOutput("rd_sram_write",  32'(sramWrite),  32'h0);
        checkOutput("rd_sram_enable", 32'(sramEnable), 32'h1);
        drain();

        // Reset between the two beats of a req0 burst with a read in flight.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h50, 16'h0);
        #1;
        checkOutput("mid_first_ready", 32'(reqReady), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h51, 16'h0);
        reset_b = 1'b0;
        #1;
        checkOutput("mid_reset_ready",  32'(reqReady),   32'h0);
        checkOutput("mid_reset_enable", 32'(sramEnable), 32'h0);
        checkOutput("mid_reset_rsp_v",  32'(rspValid),   32'h0);
        checkOutput("mid_reset_rsp_d",  32'(rspData),    32'h0);
        clearAll();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'h52, 16'h0);
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(reqReady), 32'h2);
        expectRead(3'b010, 16'hA052);
        nextCycle();
        clearAll();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
